data_memory_hs: RTL and testbench
=================================

// Module: data_memory_hs
// PURPOSE
//  - Byte-addressable 32-bit data memory with parametrised depth and a valid/ready request/response handshake.
//  - Adds a programmable response latency and true byte/half-word lane placement from addr[1:0].
//  - Flags out-of-range, reserved-size and (optionally) misaligned accesses.
//  - Sits behind the LSU of the multi-cycle core and replaces the combinational data memory there.
// PARAMETERS
//  DEPTH      32                       number of 32-bit words; power of two, >=4; AW = $clog2(DEPTH)
//  LATENCY    1                        cycles from request acceptance to rsp_valid; legal range 1..15
//  INIT_FILE  "data/data_memory.mem"   $readmemh image loaded at time 0; "" = no load
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst_n          in   1   asynchronous active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   block can accept a request (IDLE only)
//  req_write      in   1   1 = store, 0 = load
//  req_size       in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned   in   1   loads only: 1 = zero-extend, 0 = sign-extend
//  req_addr       in   32  byte address
//  req_wdata      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid      out  1   response present; held until rsp_ready
//  rsp_ready      in   1   consumer takes the response
//  rsp_rdata      out  32  extended load data; 0 for stores and errored accesses
//  rsp_err        out  1   access suppressed (range/size/misalign)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
//    Memory contents are not reset. Reset mid-transaction drops that transaction; a store already accepted has already committed.
//  - Accept when req_valid && req_ready at a posedge. On that edge:
//    all request fields are decoded, the store commits, and the load word is captured into a holding register.
//    Subsequent port changes have no effect on the transaction.
//  - Word index = addr[AW+1:2]. Range error when addr >= 4*DEPTH. Size error when size == 11.
//  - Store lanes: byte -> lane addr[1:0], data = wdata[7:0].
//    Half -> lanes {addr[1],0} and {addr[1],1}, data = wdata[15:0].
//    Word -> all 4 lanes. Unselected lanes keep their old contents.
//  - Load: byte/half are extracted from the selected lane(s), shifted to bit 0, then zero- or sign-extended per req_unsigned.
//    Word is returned as stored; req_unsigned is ignored for word loads.
//  - An errored access writes nothing, returns rsp_rdata=0 and rsp_err=1, and still completes the handshake with the same latency.
//  - FSM:
//    IDLE  --accept, LATENCY==1--> RESP
//    IDLE  --accept, LATENCY>1-->  WAIT (counter loaded with LATENCY-1)
//    WAIT  --counter decrements; leaves when counter==1--> RESP
//    RESP  --rsp_ready--> IDLE
//  - rsp_valid=1 only in RESP; it first rises exactly LATENCY cycles after the acceptance edge.
//    rsp_rdata and rsp_err are stable while rsp_valid=1.
//  - req_ready=1 only in IDLE. Sustained throughput is 1 transaction per LATENCY+1 cycles when rsp_ready is tied high.
//  - rsp_ready while rsp_valid=0 is ignored. A stalled response (rsp_ready=0) holds RESP indefinitely.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN
//    defined:   half with addr[0]!=0, or word with addr[1:0]!=0, is an error: suppressed, rsp_err=1, rdata=0.
//    undefined: low address bits are forced to natural alignment (half clears addr[0], word clears addr[1:0]);
//               the access is performed and no misalignment error is raised.
//               Range and size errors are unaffected.
// TESTING
//  1. Reset with rst_n=0 mid-WAIT (LATENCY=3) -> req_ready=1, rsp_valid=0 and rsp_rdata=0 immediately, without a clock edge.
//  2. Store word 0x8899AABB @0x10, then store byte 0x5A @0x12 ->
//     load word @0x10 = 0x885AAABB; load byte signed @0x13 = 0xFFFFFF88; load byte unsigned @0x13 = 0x00000088.
//  3. Store half 0xF00D @0x06, then load half signed @0x06 -> 0xFFFFF00D; lanes 0-1 of word 1 are unchanged.
//  4. LATENCY=4, rsp_ready held 0 for 3 cycles after rsp_valid rises ->
//     rsp_valid rises 4 cycles after acceptance; data is stable while held; req_ready stays 0 until 1 cycle after the rsp_ready handshake.
//  5. DEPTH=32, load @0x80 or size=11 -> rsp_err=1, rdata=0, memory unchanged.
//  6. Word load @0x0E:
//     with DMEM_MISALIGN_TRAP_EN -> rsp_err=1;
//     without it -> returns word @0x0C, rsp_err=0.

Source files
------------

// File: rtl/data_memory_hs.sv
// rtl/data_memory_hs.sv - byte-addressable 32-bit data memory with valid/ready handshake and programmable latency
// Define DMEM_MISALIGN_TRAP_EN to raise errors on misaligned half/word accesses instead of forcing alignment.
module data_memory_hs #(
  parameter int    DEPTH     = 32,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = "data/data_memory.mem"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          size_err;
  logic          range_err;
  logic          mis_err;
  logic          acc_err;
  logic [1:0]    lo;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [31:0]   rword;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   ld_data;

  assign accept = req_valid && (state == S_IDLE);
  assign idx    = req_addr[AW+1:2];
  assign rword  = mem[idx];

  // Request decode; lo is the effective lane offset after any alignment forcing
  always_comb begin
    size_err  = (req_size == 2'b11);
    range_err = |req_addr[31:AW+2];
    lo        = req_addr[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_err   = ((req_size == 2'b01) && req_addr[0]) ||
                ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    mis_err   = 1'b0;
    if (req_size == 2'b01) begin
      lo[0] = 1'b0;
    end else if (req_size == 2'b10) begin
      lo = 2'b00;
    end
`endif
    acc_err   = size_err || range_err || mis_err;
  end

  // Store lane enables and lane-replicated write data
  always_comb begin
    be = 4'b0000;
    wd = req_wdata;
    case (req_size)
      2'b00: begin
        be = 4'b0001 << lo;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = lo[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Load extraction and extension
  always_comb begin
    case (lo)
      2'b00:   byte_sel = rword[7:0];
      2'b01:   byte_sel = rword[15:8];
      2'b10:   byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = lo[1] ? rword[31:16] : rword[15:0];
    case (req_size)
      2'b00:   ld_data = req_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_data = req_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b10:   ld_data = rword;
      default: ld_data = 32'h0;
    endcase
  end

  // Memory array is not reset; stores commit on the acceptance edge
  always_ff @(posedge clk) begin
    if (accept && req_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wd[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd1) begin
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      cnt     <= 4'(LATENCY - 1);
      rdata_q <= (req_write || acc_err) ? 32'h0 : ld_data;
      err_q   <= acc_err;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    rsp_err   = rsp_valid && err_q;
  end

endmodule

// File: tb/tb_data_memory_hs.sv
// tb/tb_data_memory_hs.sv - randomized self-checking bench for data_memory_hs against a byte-array model
module tb_data_memory_hs;

  localparam int DEPTH = 32;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  byte unsigned mm [DEPTH*4];
  logic [31:0]  fill [DEPTH];

  always #5 clk = ~clk;

  data_memory_hs #(
    .DEPTH(DEPTH),
    .LATENCY(LAT),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_size(req_size),
    .req_unsigned(req_unsigned),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Little-endian byte-array reference; returns {err, rdata}
  task automatic model(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wdat, output logic [32:0] res);
    logic [31:0] a;
    logic [31:0] v;
    bit          err;
    int          n;
    a   = addr;
    err = (sz == 2'b11) || (addr >= 32'(DEPTH*4));
`ifdef DMEM_MISALIGN_TRAP_EN
    if (sz == 2'b01 && (addr % 2) != 0) err = 1'b1;
    if (sz == 2'b10 && (addr % 4) != 0) err = 1'b1;
`else
    if (sz == 2'b01) a = addr - (addr % 2);
    if (sz == 2'b10) a = addr - (addr % 4);
`endif
    v = 32'h0;
    if (err) begin
      res = {1'b1, 32'h0};
    end else begin
      n = 1 << sz;
      for (int i = 0; i < n; i++) begin
        if (wr) mm[a+i] = wdat[8*i +: 8];
        else    v = v | (32'(mm[a+i]) << (8*i));
      end
      if (!wr && n < 4 && !uns && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      res = {1'b0, wr ? 32'h0 : v};
    end
  endtask

  task automatic do_op(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdat, input int stall,
                       output logic [31:0] rd, output logic er);
    logic [32:0] e;
    int          n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdat;
    @(posedge clk);
    #1;
    model(wr, sz, uns, addr, wdat, e);
    req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    rd = rsp_rdata;
    er = rsp_err;
    check({tag, "_rdata"}, rd, e[31:0]);
    check({tag, "_err"}, 32'(er), 32'(e[32]));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_rdata"}, rsp_rdata, e[31:0]);
      check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, "_post_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [32:0] e;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;

    for (int w = 0; w < DEPTH; w++) begin
      fill[w] = $urandom;
      do_op("fill", 1'b1, 2'b10, 1'b0, 32'(w*4), fill[w], 0, rd, er);
    end

    do_op("t2_sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB, 0, rd, er);
    do_op("t2_sb", 1'b1, 2'b00, 1'b0, 32'h12, 32'h0000005A, 0, rd, er);
    do_op("t2_lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, rd, er);
    check("t2_lw_val", rd, 32'h885AAABB);
    do_op("t2_lbs", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, rd, er);
    check("t2_lbs_val", rd, 32'hFFFFFF88);
    do_op("t2_lbu", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, rd, er);
    check("t2_lbu_val", rd, 32'h00000088);

    do_op("t3_sh", 1'b1, 2'b01, 1'b0, 32'h06, 32'h1234F00D, 0, rd, er);
    do_op("t3_lhs", 1'b0, 2'b01, 1'b0, 32'h06, 32'h0, 0, rd, er);
    check("t3_lhs_val", rd, 32'hFFFFF00D);
    do_op("t3_lhu_lo", 1'b0, 2'b01, 1'b1, 32'h04, 32'h0, 0, rd, er);
    check("t3_lanes01", rd, {16'h0, fill[1][15:0]});

    do_op("t5_lrange", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 0, rd, er);
    check("t5_lrange_err", 32'(er), 32'd1);
    check("t5_lrange_rdata", rd, 32'h0);
    do_op("t5_srange", 1'b1, 2'b10, 1'b0, 32'h80, 32'hDEADBEEF, 0, rd, er);
    do_op("t5_ssize", 1'b1, 2'b11, 1'b0, 32'h20, 32'hDEADBEEF, 0, rd, er);
    check("t5_ssize_err", 32'(er), 32'd1);
    do_op("t5_lw0", 1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 0, rd, er);
    check("t5_word0_kept", rd, fill[0]);
    do_op("t5_lw8", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0, rd, er);
    check("t5_word8_kept", rd, fill[8]);

    do_op("t6_lw_mis", 1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("t6_trap_err", 32'(er), 32'd1);
    check("t6_trap_rdata", rd, 32'h0);
`else
    check("t6_align_err", 32'(er), 32'd0);
    check("t6_align_rdata", rd, fill[3]);
`endif

    do_op("t4_stall", 1'b0, 2'b10, 1'b0, 32'h18, 32'h0, 3, rd, er);
    check("t4_stall_val", rd, fill[6]);

    // Reset lands in WAIT after a store has already committed
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    model(1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, e);
    req_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_req_ready", 32'(req_ready), 32'd1);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("t1_lw", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 0, rd, er);
    check("t1_committed", rd, 32'hCAFEF00D);

    for (int k = 0; k < 150; k++) begin
      do_op("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, DEPTH*4 + 15)), $urandom, int'($urandom_range(0, 2)), rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
